// File: rtl/dual_issue_regfile_pkg.sv
// Shared register-file definitions for the dual-issue pipeline.
package dual_issue_regfile_pkg;

    localparam int REG_DATA_W = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] word_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_read_port.sv
// One register-file read port with same-cycle WB bypass.
// Priority: r0 reads zero, then the slave (younger) WB write, then the master
// WB write, then the stored entry.
module regfile_read_port
    import dual_issue_regfile_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic [ADDR_W-1:0] rdAddr_i,
    input  logic              masterWbEn_i,
    input  logic [ADDR_W-1:0] masterWbAddr_i,
    input  logic [DATA_W-1:0] masterWbData_i,
    input  logic              slaveWbEn_i,
    input  logic [ADDR_W-1:0] slaveWbAddr_i,
    input  logic [DATA_W-1:0] slaveWbData_i,
    input  logic [DATA_W-1:0] storedData_i,
    output logic [DATA_W-1:0] rdData_o
);

    // Select the freshest value for this address, younger writer first.
    always_comb begin
        rdData_o = storedData_i;
        if (rdAddr_i == ADDR_W'(REG_ZERO)) begin
            rdData_o = '0;
        end else if (slaveWbEn_i && (slaveWbAddr_i == rdAddr_i)) begin
            rdData_o = slaveWbData_i;
        end else if (masterWbEn_i && (masterWbAddr_i == rdAddr_i)) begin
            rdData_o = masterWbData_i;
        end
    end

endmodule

// File: rtl/dual_issue_regfile.sv
// 32 x 32 general-purpose register file: four bypassed read ports, two write
// ports. r0 has no storage and always reads zero. When both writers target
// the same register in one cycle the slave (younger instruction) wins.
module dual_issue_regfile
    import dual_issue_regfile_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              master_wb_reg_en,
    input  logic [ADDR_W-1:0] master_wb_addr,
    input  logic [DATA_W-1:0] master_wb_data,
    input  logic              slave_wb_reg_en,
    input  logic [ADDR_W-1:0] slave_wb_addr,
    input  logic [DATA_W-1:0] slave_wb_data,
    input  logic [ADDR_W-1:0] master_rs_addr,
    input  logic [ADDR_W-1:0] master_rt_addr,
    input  logic [ADDR_W-1:0] slave_rs_addr,
    input  logic [ADDR_W-1:0] slave_rt_addr,
    output logic [DATA_W-1:0] master_rs_data,
    output logic [DATA_W-1:0] master_rt_data,
    output logic [DATA_W-1:0] slave_rs_data,
    output logic [DATA_W-1:0] slave_rt_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [1:DEPTH-1];
    logic [DATA_W-1:0] regs_d [1:DEPTH-1];
    logic [DATA_W-1:0] regView [0:DEPTH-1];

    logic [ADDR_W-1:0] rdAddr [4];
    logic [DATA_W-1:0] rdData [4];

    // Next-state of the array: master write first so a colliding slave write overrides it.
    always_comb begin
        regs_d = regs_q;
        if (master_wb_reg_en && (master_wb_addr != ADDR_W'(REG_ZERO))) begin
            regs_d[master_wb_addr] = master_wb_data;
        end
        if (slave_wb_reg_en && (slave_wb_addr != ADDR_W'(REG_ZERO))) begin
            regs_d[slave_wb_addr] = slave_wb_data;
        end
    end

    // Storage update; reset clears every stored entry and ignores both writers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 1; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Full-depth view with a hard-wired zero entry so read ports can index any address.
    assign regView[0] = '0;
    for (genvar g = 1; g < DEPTH; g++) begin : gen_view
        assign regView[g] = regs_q[g];
    end

    assign rdAddr[0] = master_rs_addr;
    assign rdAddr[1] = master_rt_addr;
    assign rdAddr[2] = slave_rs_addr;
    assign rdAddr[3] = slave_rt_addr;

    for (genvar p = 0; p < 4; p++) begin : gen_rd
        regfile_read_port #(
            .DATA_W(DATA_W),
            .ADDR_W(ADDR_W)
        ) u_read_port (
            .rdAddr_i      (rdAddr[p]),
            .masterWbEn_i  (master_wb_reg_en),
            .masterWbAddr_i(master_wb_addr),
            .masterWbData_i(master_wb_data),
            .slaveWbEn_i   (slave_wb_reg_en),
            .slaveWbAddr_i (slave_wb_addr),
            .slaveWbData_i (slave_wb_data),
            .storedData_i  (regView[rdAddr[p]]),
            .rdData_o      (rdData[p])
        );
    end

    assign master_rs_data = rdData[0];
    assign master_rt_data = rdData[1];
    assign slave_rs_data  = rdData[2];
    assign slave_rt_data  = rdData[3];

endmodule

// File: tb/tb_dual_issue_regfile.sv
// Directed bench for dual_issue_regfile: reset, dual writes, write conflict,
// same-cycle bypass, r0 protection and reset in the middle of operation.
module tb_dual_issue_regfile;
    import dual_issue_regfile_pkg::*;

    logic      clk;
    logic      rst_n;
    logic      master_wb_reg_en;
    reg_addr_t master_wb_addr;
    word_t     master_wb_data;
    logic      slave_wb_reg_en;
    reg_addr_t slave_wb_addr;
    word_t     slave_wb_data;
    reg_addr_t master_rs_addr;
    reg_addr_t master_rt_addr;
    reg_addr_t slave_rs_addr;
    reg_addr_t slave_rt_addr;
    word_t     master_rs_data;
    word_t     master_rt_data;
    word_t     slave_rs_data;
    word_t     slave_rt_data;

    int checkCount = 0;
    int errCount   = 0;

    dual_issue_regfile dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .master_wb_reg_en(master_wb_reg_en),
        .master_wb_addr  (master_wb_addr),
        .master_wb_data  (master_wb_data),
        .slave_wb_reg_en (slave_wb_reg_en),
        .slave_wb_addr   (slave_wb_addr),
        .slave_wb_data   (slave_wb_data),
        .master_rs_addr  (master_rs_addr),
        .master_rt_addr  (master_rt_addr),
        .slave_rs_addr   (slave_rs_addr),
        .slave_rt_addr   (slave_rt_addr),
        .master_rs_data  (master_rs_data),
        .master_rt_data  (master_rt_data),
        .slave_rs_data   (slave_rs_data),
        .slave_rt_data   (slave_rt_data)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input word_t obs, input word_t exp);
        checkCount++;
        if (obs !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Drive both writeback triples.
    task automatic applyStimulus(input logic men, input reg_addr_t maddr, input word_t mdata,
                                 input logic sen, input reg_addr_t saddr, input word_t sdata);
        master_wb_reg_en = men;
        master_wb_addr   = maddr;
        master_wb_data   = mdata;
        slave_wb_reg_en  = sen;
        slave_wb_addr    = saddr;
        slave_wb_data    = sdata;
    endtask

    task automatic setReads(input reg_addr_t a, input reg_addr_t b,
                            input reg_addr_t c, input reg_addr_t d);
        master_rs_addr = a;
        master_rt_addr = b;
        slave_rs_addr  = c;
        slave_rt_addr  = d;
    endtask

    // Advance past the next rising edge so new inputs land mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleWb();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        idleWb();
        setReads(5'd0, 5'd0, 5'd0, 5'd0);

        // Reset held for two edges, then every address on every port reads zero.
        tick();
        tick();
        for (int a = 0; a < 32; a++) begin
            setReads(5'(a), 5'(a), 5'(a), 5'(a));
            #1;
            checkOutput($sformatf("reset_mrs_r%0d", a), master_rs_data, 32'h0);
            checkOutput($sformatf("reset_mrt_r%0d", a), master_rt_data, 32'h0);
            checkOutput($sformatf("reset_srs_r%0d", a), slave_rs_data, 32'h0);
            checkOutput($sformatf("reset_srt_r%0d", a), slave_rt_data, 32'h0);
        end
        rst_n = 1'b1;
        tick();

        // Dual write to different registers.
        applyStimulus(1'b1, 5'd5, 32'h1111_2222, 1'b1, 5'd6, 32'h3333_4444);
        tick();
        idleWb();
        setReads(5'd5, 5'd6, 5'd0, 5'd6);
        #1;
        checkOutput("dual_mrs_r5", master_rs_data, 32'h1111_2222);
        checkOutput("dual_mrt_r6", master_rt_data, 32'h3333_4444);
        checkOutput("dual_srs_r0", slave_rs_data, 32'h0);
        checkOutput("dual_srt_r6", slave_rt_data, 32'h3333_4444);

        // Both writers target r7: slave data is kept.
        applyStimulus(1'b1, 5'd7, 32'hAAAA_0000, 1'b1, 5'd7, 32'hBBBB_0000);
        tick();
        idleWb();
        setReads(5'd7, 5'd7, 5'd7, 5'd7);
        #1;
        checkOutput("conflict_mrs", master_rs_data, 32'hBBBB_0000);
        checkOutput("conflict_mrt", master_rt_data, 32'hBBBB_0000);
        checkOutput("conflict_srs", slave_rs_data, 32'hBBBB_0000);
        checkOutput("conflict_srt", slave_rt_data, 32'hBBBB_0000);

        // Same-cycle bypass on r8.
        applyStimulus(1'b1, 5'd8, 32'h10, 1'b0, 5'd0, 32'h0);
        tick();
        idleWb();
        setReads(5'd8, 5'd5, 5'd8, 5'd6);
        #1;
        checkOutput("bypass_stored", slave_rs_data, 32'h10);
        applyStimulus(1'b1, 5'd8, 32'h20, 1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("bypass_master", slave_rs_data, 32'h20);
        checkOutput("bypass_master_mrs", master_rs_data, 32'h20);
        checkOutput("bypass_other_reg", master_rt_data, 32'h1111_2222);
        applyStimulus(1'b1, 5'd8, 32'h20, 1'b1, 5'd8, 32'h30);
        #1;
        checkOutput("bypass_slave", slave_rs_data, 32'h30);
        checkOutput("bypass_slave_mrs", master_rs_data, 32'h30);
        tick();
        idleWb();
        #1;
        checkOutput("bypass_after", master_rs_data, 32'h30);

        // r0 writes are discarded and never bypassed.
        applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'hFFFF_FFFF);
        setReads(5'd0, 5'd0, 5'd0, 5'd0);
        #1;
        checkOutput("r0_same_mrs", master_rs_data, 32'h0);
        checkOutput("r0_same_srt", slave_rt_data, 32'h0);
        tick();
        idleWb();
        #1;
        checkOutput("r0_after_mrt", master_rt_data, 32'h0);
        checkOutput("r0_after_srs", slave_rs_data, 32'h0);

        // Reset in the middle of operation.
        applyStimulus(1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 32'h0);
        tick();
        idleWb();
        setReads(5'd9, 5'd5, 5'd9, 5'd6);
        #1;
        checkOutput("midrst_stored", master_rs_data, 32'h55);
        rst_n = 1'b0;
        applyStimulus(1'b1, 5'd9, 32'h66, 1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("midrst_bypass", slave_rs_data, 32'h66);
        tick();
        idleWb();
        #1;
        checkOutput("midrst_r9_cleared", master_rs_data, 32'h0);
        checkOutput("midrst_r5_cleared", master_rt_data, 32'h0);
        checkOutput("midrst_r6_cleared", slave_rt_data, 32'h0);
        rst_n = 1'b1;
        applyStimulus(1'b1, 5'd9, 32'h77, 1'b0, 5'd0, 32'h0);
        tick();
        idleWb();
        #1;
        checkOutput("midrst_rewrite", master_rs_data, 32'h77);
        checkOutput("midrst_rewrite_srs", slave_rs_data, 32'h77);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errCount);
        $finish;
    end

endmodule
